multdiv_sequencer: RTL

MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

---
 rtl/multdiv_sequencer.sv | 87 ++++++++
 1 files changed

// File: rtl/multdiv_sequencer.sv
// Sequences a multi-cycle mult/div through an external multdiv unit: latches
// operands, pulses start, stalls the pipeline until ready or timeout, and captures the result.
module multdiv_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_mult,
  input  logic        issue_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        md_start_mult,
  output logic        md_start_div,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_rdy,
  output logic        stall,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        exception,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       op_mult;
  logic [7:0] cnt;
  logic       issue;

  assign issue = issue_mult | issue_div;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op_mult   <= 1'b0;
      md_a      <= '0;
      md_b      <= '0;
      result    <= '0;
      exception <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (issue) begin
          md_a    <= op_a;
          md_b    <= op_b;
          op_mult <= issue_mult;  // both lines high resolves to mult
          state   <= START;
        end
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (md_rdy) begin
            result    <= md_result;
            exception <= md_exception;
            state     <= DONE;
          end else if (cnt == CNT_LAST) begin
            result    <= '0;
            exception <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the state register; held low while reset is asserted.
  assign md_start_mult = reset & (state == START) & op_mult;
  assign md_start_div  = reset & (state == START) & ~op_mult;
  assign result_valid  = reset & (state == DONE);
  assign busy          = reset & ((state == START) | (state == WAIT));
  assign stall         = reset & ~flush &
                         (((state == IDLE) & issue) | (state == START) | (state == WAIT));

endmodule
